serdes_frame_tx: RTL and testbench
==================================

Name: serdes_frame_tx

Overview:
- Upstream framing stage for the secure SERDES encrypt core.
- Accepts parallel data/key byte pairs over a valid/ready handshake and buffers one pair.
- Emits the serial frame the encrypt core consumes: a one-cycle start pulse, then DATA_W cycles of a_bit/b_bit, MSB first, one bit per clock.
- Enforces a minimum idle gap between frames so the downstream core can present cipher and filter outputs.

Parameters:
DATA_W, 8, bits per frame; width of in_a/in_b.
GAP_CYCLES, 2, idle cycles (start=0, bits=0) after the last bit before the next start; 0 is legal.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
ena  input  1  enable; gates frame launch only
in_valid  input  1  upstream offers a byte pair
in_ready  output  1  holding buffer empty; pair accepted when in_valid&&in_ready at a clock edge
in_a  input  DATA_W  data byte (feeds a_bit)
in_b  input  DATA_W  key byte (feeds b_bit)
start  output  1  one-cycle frame start pulse to the encrypt core
a_bit  output  1  serial data bit
b_bit  output  1  serial key bit
busy  output  1  high in START, SHIFT and GAP
frame_done  output  1  one-cycle pulse in the cycle after the LSB cycle

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- All outputs are registered.
- Reset: state=IDLE, hold buffer empty, shift regs=0. Outputs: start=0, a_bit=0, b_bit=0, busy=0, frame_done=0, in_ready=1 (visible after the reset edge).
- Reset mid-frame aborts immediately. No partial bits follow; the held pair is discarded.
- Hold buffer: 1 entry. in_ready = ~hold_full.
  - Accept edge sets hold_full.
  - A launch clears hold_full. Launch and accept on the same edge are legal, so hold_full stays 1 with the new pair.
- States:
  - IDLE: if hold_full && ena, load shift regs from hold and go to START.
  - START: start=1, a_bit=b_bit=0. Next state SHIFT with bit index DATA_W-1.
  - SHIFT: a_bit/b_bit = shift reg MSB. Shift left each cycle for DATA_W cycles (MSB first). After the LSB cycle go to GAP, or if GAP_CYCLES=0 use the launch rule below.
  - GAP: start=0, bits=0, for GAP_CYCLES cycles. frame_done=1 in the first cycle after SHIFT. With GAP_CYCLES=0, frame_done is asserted in the following START or IDLE cycle instead.
  - Launch rule at end of GAP: if hold_full && ena, go directly to START (no IDLE cycle); else go to IDLE.
- Latency: pair accepted at edge E with the FSM idle and ena=1 → start high in cycle E+1..E+2, MSB in the following cycle.
- Back-to-back frame period: 1 + DATA_W + GAP_CYCLES cycles (11 by default).
- ena=0 never interrupts a frame in progress. It only blocks leaving IDLE or GAP-end. Acceptance into the hold buffer continues regardless of ena.
- in_a/in_b are sampled only on the accept edge; later changes are ignored.
- Counters wrap-free: bit index counts DATA_W-1..0, gap counter 0..GAP_CYCLES-1, both reloaded at every state entry.

Optional Feature:
- Macro: SERDES_TX_STATS_EN.
- Defined: adds output frame_cnt[7:0]. It increments (mod 256, 255→0) on each frame_done pulse and resets to 0 on rst.
- Defined: adds output stall_flag[0]. It is a sticky flag, set when in_valid=1 && in_ready=0 on any edge, and cleared only by rst.
- Not defined: neither port exists, no counter logic is synthesized, and all other behaviour is identical.

Test Plan:
- Reset, ena=1, offer in_a=8'hA5, in_b=8'h3C for one cycle → start pulse 1 cycle; a_bit sequence 1,0,1,0,0,1,0,1; b_bit sequence 0,0,1,1,1,1,0,0; frame_done 1 cycle later; busy=0 after 2 gap cycles.
- Two pairs offered back-to-back (A5/3C then 5A/C3) → second start exactly 11 cycles after the first; in_ready drops while the second pair is held; no IDLE cycle between frames.
- rst asserted at the 4th bit of a frame → next cycle all outputs 0, in_ready=1; after release, no residual bits and no start.
- ena=0 with a pair accepted → no start while ena=0, in_ready=0; ena raised → start on the next edge; ena dropped mid-frame → frame completes all 8 bits.
- GAP_CYCLES=0 build, three back-to-back pairs → start period 9 cycles; frame_done coincides with the next start cycle.
- SERDES_TX_STATS_EN defined: 257 frames → frame_cnt=1; in_valid held while in_ready=0 → stall_flag=1, persisting until rst.

Source files
------------

// File: rtl/serdes_frame_tx.sv
// Framing stage ahead of the SERDES encrypt core: holds one data/key pair and
// serialises it MSB first behind a start pulse. SERDES_TX_STATS_EN adds frame_cnt/stall_flag.
module serdes_frame_tx #(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              start,
  output logic              a_bit,
  output logic              b_bit,
  output logic              busy,
  output logic              frame_done
`ifdef SERDES_TX_STATS_EN
  ,
  output logic [7:0]        frame_cnt,
  output logic              stall_flag
`endif
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BW-1:0] BIT_FIRST = BW'(DATA_W - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] hold_a_q, hold_a_d, hold_b_q, hold_b_d;
  logic [DATA_W-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d;
  logic [BW-1:0]     bit_idx_q, bit_idx_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic              start_q, a_bit_q, b_bit_q, busy_q, frame_done_q, in_ready_q;
  logic              accept, launch, last_bit;

  // Next state, hold buffer and shift registers; launch and accept may share an edge.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    gap_cnt_d = gap_cnt_q;
    launch    = 1'b0;
    accept    = in_valid && !hold_full_q;
    last_bit  = (state_q == SHIFT) && (bit_idx_q == {BW{1'b0}});
    case (state_q)
      IDLE: begin
        if (hold_full_q && ena) begin
          launch  = 1'b1;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        state_d   = SHIFT;
        bit_idx_d = BIT_FIRST;
      end
      SHIFT: begin
        if (!last_bit) begin
          bit_idx_d = bit_idx_q - 1'b1;
        end else if (GAP_CYCLES > 0) begin
          state_d   = GAP;
          gap_cnt_d = {GW{1'b0}};
        end else if (hold_full_q && ena) begin
          launch  = 1'b1;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt_q != GAP_LAST) begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end else if (hold_full_q && ena) begin
          launch  = 1'b1;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    hold_full_d = accept || (hold_full_q && !launch);
    hold_a_d    = accept ? in_a : hold_a_q;
    hold_b_d    = accept ? in_b : hold_b_q;

    // The shift only starts once the MSB has been shown, so START leaves the regs untouched.
    if (launch) begin
      sh_a_d = hold_a_q;
      sh_b_d = hold_b_q;
    end else if (state_q == SHIFT) begin
      sh_a_d = sh_a_q << 1;
      sh_b_d = sh_b_q << 1;
    end else begin
      sh_a_d = sh_a_q;
      sh_b_d = sh_b_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      hold_full_q  <= 1'b0;
      hold_a_q     <= {DATA_W{1'b0}};
      hold_b_q     <= {DATA_W{1'b0}};
      sh_a_q       <= {DATA_W{1'b0}};
      sh_b_q       <= {DATA_W{1'b0}};
      bit_idx_q    <= {BW{1'b0}};
      gap_cnt_q    <= {GW{1'b0}};
      start_q      <= 1'b0;
      a_bit_q      <= 1'b0;
      b_bit_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      hold_full_q  <= hold_full_d;
      hold_a_q     <= hold_a_d;
      hold_b_q     <= hold_b_d;
      sh_a_q       <= sh_a_d;
      sh_b_q       <= sh_b_d;
      bit_idx_q    <= bit_idx_d;
      gap_cnt_q    <= gap_cnt_d;
      start_q      <= (state_d == START);
      a_bit_q      <= (state_d == SHIFT) && sh_a_d[DATA_W-1];
      b_bit_q      <= (state_d == SHIFT) && sh_b_d[DATA_W-1];
      busy_q       <= (state_d != IDLE);
      frame_done_q <= last_bit;
      in_ready_q   <= !hold_full_d;
    end
  end

  assign start      = start_q;
  assign a_bit      = a_bit_q;
  assign b_bit      = b_bit_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign in_ready   = in_ready_q;

`ifdef SERDES_TX_STATS_EN
  logic [7:0] frame_cnt_q;
  logic       stall_flag_q;

  // Counter tracks the frame_done register so both change in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q  <= 8'd0;
      stall_flag_q <= 1'b0;
    end else begin
      frame_cnt_q  <= last_bit ? (frame_cnt_q + 8'd1) : frame_cnt_q;
      stall_flag_q <= stall_flag_q || (in_valid && hold_full_q);
    end
  end

  assign frame_cnt  = frame_cnt_q;
  assign stall_flag = stall_flag_q;
`endif

endmodule

// File: tb/tb_serdes_frame_tx.sv
// Bench for serdes_frame_tx: two instances (gap 2 and gap 0) checked every cycle against a
// frame-position model, plus literal checks on the A5/3C frame, frame period and reset.
module tb_serdes_frame_tx;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst, ena, in_valid;
  logic [7:0] in_a, in_b;
  logic       st[2], ab[2], bb[2], bz[2], fd[2], rdy[2];
`ifdef SERDES_TX_STATS_EN
  logic [7:0] fc[2];
  logic       sf[2];
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: per instance, frame position 0=start, 1..W=bits, W+1..W+gap=gap.
  bit         m_act[2];
  int         m_pos[2];
  bit         m_hf[2];
  logic [7:0] m_ha[2], m_hb[2], m_fa[2], m_fb[2];
  bit         m_done[2];
  logic [7:0] m_cnt[2];
  bit         m_stall[2];
  int         gap_of[2] = '{2, 0};
  int         start_cyc[2][$];

  always #5 clk = ~clk;

  serdes_frame_tx #(.DATA_W(8), .GAP_CYCLES(2)) u0 (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_a(in_a), .in_b(in_b), .start(st[0]), .a_bit(ab[0]), .b_bit(bb[0]),
    .busy(bz[0]), .frame_done(fd[0])
`ifdef SERDES_TX_STATS_EN
    , .frame_cnt(fc[0]), .stall_flag(sf[0])
`endif
  );

  serdes_frame_tx #(.DATA_W(8), .GAP_CYCLES(0)) u1 (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_a(in_a), .in_b(in_b), .start(st[1]), .a_bit(ab[1]), .b_bit(bb[1]),
    .busy(bz[1]), .frame_done(fd[1])
`ifdef SERDES_TX_STATS_EN
    , .frame_cnt(fc[1]), .stall_flag(sf[1])
`endif
  );

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] cyc=%0d got=%0h want=%0h", name, inst, cyc, act, exp);
    end
  endtask

  task automatic model_update(input int i);
    bit old_hf, acc, free, launch;
    int flen;
    flen = 1 + W + gap_of[i];
    if (rst) begin
      m_act[i] = 0; m_pos[i] = 0; m_hf[i] = 0; m_done[i] = 0;
      m_cnt[i] = 8'd0; m_stall[i] = 0;
      return;
    end
    old_hf = m_hf[i];
    acc    = in_valid && !old_hf;
    if (in_valid && old_hf) m_stall[i] = 1;
    m_done[i] = m_act[i] && (m_pos[i] == W);
    free   = !m_act[i] || (m_pos[i] == flen - 1);
    launch = free && old_hf && ena;
    if (launch) begin
      m_act[i] = 1; m_pos[i] = 0; m_fa[i] = m_ha[i]; m_fb[i] = m_hb[i];
    end else if (free) begin
      m_act[i] = 0; m_pos[i] = 0;
    end else begin
      m_pos[i]++;
    end
    m_hf[i] = (old_hf && !launch) || acc;
    if (acc) begin
      m_ha[i] = in_a; m_hb[i] = in_b;
    end
    if (m_done[i]) m_cnt[i] = m_cnt[i] + 8'd1;
  endtask

  task automatic compare(input int i);
    bit   shifting;
    logic ea, eb;
    shifting = m_act[i] && (m_pos[i] >= 1) && (m_pos[i] <= W);
    ea = shifting ? m_fa[i][W - m_pos[i]] : 1'b0;
    eb = shifting ? m_fb[i][W - m_pos[i]] : 1'b0;
    chk("start", i, st[i], m_act[i] && (m_pos[i] == 0));
    chk("a_bit", i, ab[i], ea);
    chk("b_bit", i, bb[i], eb);
    chk("busy", i, bz[i], m_act[i]);
    chk("frame_done", i, fd[i], m_done[i]);
    chk("in_ready", i, rdy[i], !m_hf[i]);
`ifdef SERDES_TX_STATS_EN
    chk("frame_cnt", i, fc[i], m_cnt[i]);
    chk("stall_flag", i, sf[i], m_stall[i]);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      model_update(i);
      compare(i);
      if (st[i] === 1'b1) start_cyc[i].push_back(cyc);
    end
  endtask

  initial begin
    logic [7:0] cap_a, cap_b;
    int         acc_cyc, n_done, n_start, d0, d1, accepted;

    rst = 1'b1; ena = 1'b1; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00;
    repeat (2) step();
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", i, rdy[i], 1'b1);
      chk("rst_busy", i, bz[i], 1'b0);
      chk("rst_start", i, st[i], 1'b0);
      chk("rst_bits", i, {ab[i], bb[i], fd[i]}, 3'b000);
    end
    rst = 1'b0;
    step();

    // Single A5/3C frame; data lines change after the accept edge and must be ignored.
    start_cyc[0].delete(); start_cyc[1].delete();
    in_valid = 1'b1; in_a = 8'hA5; in_b = 8'h3C;
    step();
    acc_cyc = cyc;
    in_valid = 1'b0; in_a = 8'hFF; in_b = 8'h00;
    cap_a = 8'h00; cap_b = 8'h00; n_done = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (m_act[0] && m_pos[0] >= 1 && m_pos[0] <= W) begin
        cap_a = {cap_a[6:0], ab[0]};
        cap_b = {cap_b[6:0], bb[0]};
      end
      if (fd[0] === 1'b1) n_done++;
    end
    chk("lit_a_seq", 0, cap_a, 8'hA5);
    chk("lit_b_seq", 0, cap_b, 8'h3C);
    chk("lit_done_cnt", 0, n_done, 1);
    chk("lit_idle_busy", 0, bz[0], 1'b0);
    chk("lit_latency", 0, (start_cyc[0].size() > 0) ? start_cyc[0][0] - acc_cyc : -1, 1);

    // Back-to-back pairs: frame period 11 with gap 2, 9 with gap 0.
    start_cyc[0].delete(); start_cyc[1].delete();
    in_valid = 1'b1; in_a = 8'hA5; in_b = 8'h3C;
    step();
    in_a = 8'h5A; in_b = 8'hC3;
    repeat (2) step();
    in_valid = 1'b0;
    repeat (30) step();
    d0 = (start_cyc[0].size() >= 2) ? start_cyc[0][1] - start_cyc[0][0] : -1;
    d1 = (start_cyc[1].size() >= 2) ? start_cyc[1][1] - start_cyc[1][0] : -1;
    chk("lit_period", 0, d0, 11);
    chk("lit_period", 1, d1, 9);

    // Reset at the 4th bit with a second pair held: nothing may follow.
    in_valid = 1'b1; in_a = 8'hC6; in_b = 8'h39;
    step();
    in_a = 8'h81; in_b = 8'h7E;
    for (int k = 0; k < 20; k++) begin
      if (m_act[0] && m_pos[0] == 4) break;
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("lit_rst_outs", i, {st[i], ab[i], bb[i], bz[i], fd[i]}, 5'b00000);
      chk("lit_rst_ready", i, rdy[i], 1'b1);
    end
    n_start = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (st[0] === 1'b1 || bz[0] === 1'b1) n_start++;
    end
    chk("lit_no_residual", 0, n_start, 0);

    // ena low blocks launch but not acceptance; dropping it mid-frame does not cut the frame.
    ena = 1'b0; in_valid = 1'b1; in_a = 8'h3C; in_b = 8'hA5;
    step();
    in_valid = 1'b0;
    n_start = 0;
    repeat (5) begin
      step();
      if (st[0] === 1'b1) n_start++;
    end
    chk("lit_ena_hold", 0, n_start, 0);
    chk("lit_ena_ready", 0, rdy[0], 1'b0);
    ena = 1'b1;
    step();
    chk("lit_ena_start", 0, st[0], 1'b1);
    repeat (3) step();
    ena = 1'b0;
    n_done = 0;
    repeat (12) begin
      step();
      if (fd[0] === 1'b1) n_done++;
    end
    chk("lit_ena_complete", 0, n_done, 1);
    ena = 1'b1;

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 199) == 0);
      ena      = ($urandom_range(0, 9) != 0);
      in_valid = ($urandom_range(0, 1) == 1);
      in_a     = 8'($urandom);
      in_b     = 8'($urandom);
      step();
    end
    rst = 1'b0; ena = 1'b1; in_valid = 1'b0;

`ifdef SERDES_TX_STATS_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    accepted = 0;
    in_valid = 1'b1;
    for (int n = 0; n < 4000 && accepted < 257; n++) begin
      in_a = 8'($urandom); in_b = 8'($urandom);
      if (rdy[0] === 1'b1) accepted++;
      step();
    end
    in_valid = 1'b0;
    repeat (30) step();
    chk("lit_frame_cnt", 0, fc[0], 8'd1);
    chk("lit_stall", 0, sf[0], 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("lit_stall_rst", 0, sf[0], 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
